// File: rtl/img_proc_pkg.sv
// Shared definitions for the 3x3 window control path: FSM state encoding,
// the window-pipeline alignment latency and a counter-width helper.
package img_proc_pkg;

  // Frame/line tracking states of matrix_window_ctrl.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINE = 3'd1,
    IN_LINE   = 3'd2,
    LINE_GAP  = 3'd3,
    DONE      = 3'd4
  } win_state_e;

  // Window qualifier delay that lines win_valid up with matrix_frame_clken.
  localparam int unsigned WIN_PIPE_LAT = 2;

  // Bits needed for a counter that must be able to hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Edge detector for one camera timing strobe.
// Ports:
//   clk, rst_n   - pixel clock, async active-low reset
//   sig_i        - strobe being watched
//   rise_c_o     - combinational one-cycle pulse on a 0->1 transition
//   fall_c_o     - combinational one-cycle pulse on a 1->0 transition
// The history register resets to RST_VAL; resetting it high means a rising
// edge is only reported once the strobe has actually been seen low.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic sig_q;

  // Previous-cycle value of the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= RST_VAL;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_c_o = sig_i & ~sig_q;
  assign fall_c_o = ~sig_i & sig_q;

endmodule

// File: rtl/matrix_window_ctrl.sv
// Tracks camera frame/line timing and qualifies complete 3x3 windows from the
// companion window generator, reporting the window centre coordinates.
// Ports:
//   clk, rst_n                  - pixel clock, async active-low reset
//   per_frame_vsync/href/clken  - camera timing (shared with window generator)
//   win_valid, win_x, win_y     - complete-window strobe and centre coordinates
//   frame_done, frame_abort     - one-cycle frame completion / restart pulses
//   line_err                    - sticky line-length mismatch, cleared by vsync
//   frame_cnt, abort_cnt        - status counters, only with WIN_CTRL_STATUS_EN
// Build option: define WIN_CTRL_STATUS_EN to add the status counters.
module matrix_window_ctrl
  import img_proc_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          per_frame_vsync,
  input  logic                          per_frame_href,
  input  logic                          per_frame_clken,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  output logic                          frame_done,
  output logic                          frame_abort,
  output logic                          line_err
`ifdef WIN_CTRL_STATUS_EN
  ,
  output logic [15:0]                   frame_cnt,
  output logic [7:0]                    abort_cnt
`endif
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam int unsigned CW = cnt_w(IMG_WIDTH);
  localparam int unsigned RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT);

  win_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          pix_en;
  logic          qual_c;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;

  logic vs_rise, vs_fall_unused, hr_rise, hr_fall;

  logic [WIN_PIPE_LAT-1:0] vld_q;
  logic [XW-1:0]           x_q [WIN_PIPE_LAT];
  logic [YW-1:0]           y_q [WIN_PIPE_LAT];

  sync_edge_det u_vsync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_i    (per_frame_vsync),
    .rise_c_o (vs_rise),
    .fall_c_o (vs_fall_unused)
  );

  sync_edge_det u_href_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_i    (per_frame_href),
    .rise_c_o (hr_rise),
    .fall_c_o (hr_fall)
  );

  // State, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Next state; vsync rise overrides every href event in the same cycle.
  // pix_en marks cycles where an href&clken beat belongs to a tracked line,
  // including the href-rise cycle that opens the line.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    pix_en  = 1'b0;
    if (vs_rise) begin
      abort_d = ((state_q == IN_LINE) || (state_q == LINE_GAP)) && (row_q < ROW_MAX);
      state_d = WAIT_LINE;
      col_d   = '0;
      row_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_LINE: begin
          if (hr_rise) begin
            state_d = IN_LINE;
            pix_en  = 1'b1;
          end
        end
        IN_LINE: begin
          if (hr_fall) begin
            state_d = LINE_GAP;
            row_d   = row_q + RW'(1);
            col_d   = '0;
            if (col_q != COL_MAX) err_d = 1'b1;
          end else begin
            pix_en = 1'b1;
          end
        end
        LINE_GAP: begin
          if (row_q == ROW_MAX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (hr_rise) begin
            state_d = IN_LINE;
            pix_en  = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // Pixels past the line length are dropped and flagged.
      if (pix_en && per_frame_href && per_frame_clken) begin
        if (col_q == COL_MAX) err_d = 1'b1;
        else                  col_d = col_q + CW'(1);
      end
    end
  end

  assign qual_c = pix_en & per_frame_href & per_frame_clken &
                  (row_q >= RW'(2)) & (col_q >= CW'(2)) & (col_q < COL_MAX);
  assign x_c    = XW'(col_q - CW'(1));
  assign y_c    = YW'(row_q - RW'(1));

  // Qualifier and coordinates delayed to line up with the window generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(WIN_PIPE_LAT); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= qual_c;
      x_q[0]   <= x_c;
      y_q[0]   <= y_c;
      for (int i = 1; i < int'(WIN_PIPE_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
      end
    end
  end

  assign win_valid   = vld_q[WIN_PIPE_LAT-1];
  assign win_x       = x_q[WIN_PIPE_LAT-1];
  assign win_y       = y_q[WIN_PIPE_LAT-1];
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign line_err    = err_q;

`ifdef WIN_CTRL_STATUS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  abort_cnt_q;

  // Completed frames wrap; aborted frames saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (done_q)                         frame_cnt_q <= frame_cnt_q + 16'd1;
      if (abort_q && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Self-checking bench for matrix_window_ctrl on an 8x6 image.
// The expected windows, pulses and error flag are derived from the frame/line/
// pixel structure the bench itself generates.
module tb_matrix_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken;
  logic       win_valid;
  logic [2:0] win_x;
  logic [2:0] win_y;
  logic       frame_done, frame_abort, line_err;
`ifdef WIN_CTRL_STATUS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  abort_cnt;
`endif

  matrix_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_frame_clken (per_frame_clken),
    .win_valid       (win_valid),
    .win_x           (win_x),
    .win_y           (win_y),
    .frame_done      (frame_done),
    .frame_abort     (frame_abort),
    .line_err        (line_err)
`ifdef WIN_CTRL_STATUS_EN
    ,
    .frame_cnt       (frame_cnt),
    .abort_cnt       (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs indexed by clock edge number.
  bit exp_v     [MAXC];
  int exp_x     [MAXC];
  int exp_y     [MAXC];
  bit exp_done  [MAXC];
  bit exp_abort [MAXC];
  bit exp_err;

  // Frame bookkeeping: armed = a vsync opened a frame that has not completed.
  bit armed, started, line_live;
  int row, line_pix;
  int exp_fcnt, exp_acnt;

  int cyc;
  int checks, errors;
  int n_win, n_done, n_abort;
  bit cap_first, got_first;
  int first_x, first_y;

  typedef struct {
    int nlines;
    int npix;
    int ckmode;
    int exp_wins;
    int exp_done;
    int exp_abort;
    int exp_err;
    bit chk_first;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock: drive at negedge, compare just after the posedge.
  task automatic tick(input bit vs, input bit hr, input bit ck);
    @(negedge clk);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget: edge %0d reached limit %0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
    chk("win_valid", int'(win_valid), int'(exp_v[cyc]));
    if (win_valid && exp_v[cyc]) begin
      chk("win_x", int'(win_x), exp_x[cyc]);
      chk("win_y", int'(win_y), exp_y[cyc]);
    end
    chk("frame_done", int'(frame_done), int'(exp_done[cyc]));
    chk("frame_abort", int'(frame_abort), int'(exp_abort[cyc]));
    chk("line_err", int'(line_err), int'(exp_err));
    if (win_valid) begin
      n_win++;
      if (cap_first && !got_first) begin
        got_first = 1'b1;
        first_x   = int'(win_x);
        first_y   = int'(win_y);
      end
    end
    n_done  += int'(frame_done);
    n_abort += int'(frame_abort);
  endtask

  task automatic open_frame_model();
    if (armed && started && row < H) begin
      exp_abort[cyc + 1] = 1'b1;
      if (exp_acnt < 255) exp_acnt++;
    end
    exp_err = 1'b0;
    armed   = 1'b1;
    started = 1'b0;
    row     = 0;
  endtask

  task automatic vsync_pulse();
    tick(0, 0, 0);
    tick(0, 0, 0);
    open_frame_model();
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
  endtask

  // href high until npix clken beats have been sent.
  // mode 0: continuous, 1: clken 1-0-1 pattern, 2: random clken.
  task automatic line_body(input int npix, input int mode);
    int p = 0;
    int i = 0;
    bit ck;
    line_live = armed;
    if (armed) started = 1'b1;
    while (p < npix) begin
      case (mode)
        0:       ck = 1'b1;
        1:       ck = ((i % 3) != 1);
        default: ck = ($urandom_range(0, 3) != 0);
      endcase
      if (ck) begin
        if (line_live) begin
          if (p >= W) exp_err = 1'b1;
          else if (row >= 2 && p >= 2) begin
            // window centred one pixel/line back, two clocks after this beat
            exp_v[cyc + 2] = 1'b1;
            exp_x[cyc + 2] = p - 1;
            exp_y[cyc + 2] = row - 1;
          end
        end
        p++;
      end
      tick(0, 1, ck);
      i++;
    end
    line_pix = p;
  endtask

  task automatic line_end(input int gap);
    if (line_live) begin
      row++;
      if (line_pix != W) exp_err = 1'b1;
      if (row == H) begin
        exp_done[cyc + 2] = 1'b1;
        exp_fcnt++;
        armed = 1'b0;
      end
    end
    line_live = 1'b0;
    tick(0, 0, 0);
    repeat (gap) tick(0, 0, 0);
  endtask

  task automatic send_frame(input int nlines, input int npix, input int mode);
    vsync_pulse();
    for (int l = 0; l < nlines; l++) begin
      line_body(npix, mode);
      line_end(1);
    end
    repeat (3) tick(0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_x"}, int'(win_x), 0);
    chk({tag, "_win_y"}, int'(win_y), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_frame_abort"}, int'(frame_abort), 0);
    chk({tag, "_line_err"}, int'(line_err), 0);
`ifdef WIN_CTRL_STATUS_EN
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_abort_cnt"}, int'(abort_cnt), 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bd, ba;

    //             lines npix mode wins done abort err first
    tv[0] = '{6, W,     0, 24, 1, 0, 0, 1'b1};
    tv[1] = '{3, W,     0,  6, 0, 0, 0, 1'b0};
    tv[2] = '{6, W,     0, 24, 1, 1, 0, 1'b0};
    tv[3] = '{6, W,     1, 24, 1, 0, 0, 1'b0};
    tv[4] = '{6, W + 1, 0, 24, 1, 0, 1, 1'b0};
    tv[5] = '{6, W - 1, 0, 20, 1, 0, 1, 1'b0};
    tv[6] = '{6, W,     2, 24, 1, 0, 0, 1'b0};

    checks = 0; errors = 0; cyc = 0;
    n_win = 0; n_done = 0; n_abort = 0;
    armed = 0; started = 0; line_live = 0; row = 0; line_pix = 0;
    exp_err = 0; exp_fcnt = 0; exp_acnt = 0;
    cap_first = 0; got_first = 0; first_x = 0; first_y = 0;

    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames.
    for (int t = 0; t < 7; t++) begin
      bw = n_win; bd = n_done; ba = n_abort;
      cap_first = tv[t].chk_first;
      got_first = 1'b0;
      send_frame(tv[t].nlines, tv[t].npix, tv[t].ckmode);
      chk($sformatf("vec%0d_wins", t), n_win - bw, tv[t].exp_wins);
      chk($sformatf("vec%0d_done", t), n_done - bd, tv[t].exp_done);
      chk($sformatf("vec%0d_abort", t), n_abort - ba, tv[t].exp_abort);
      chk($sformatf("vec%0d_line_err", t), int'(line_err), tv[t].exp_err);
      if (tv[t].chk_first) begin
        chk("first_win_x", first_x, 1);
        chk("first_win_y", first_y, 1);
      end
      cap_first = 1'b0;
    end

    // vsync and href rising together: the line must not be tracked.
    tick(0, 0, 0);
    tick(0, 0, 0);
    open_frame_model();
    tick(1, 1, 1);
    repeat (7) tick(0, 1, 1);
    tick(0, 0, 0);
    bw = n_win; bd = n_done;
    for (int l = 0; l < H; l++) begin
      line_body(W, 0);
      line_end(1);
    end
    repeat (3) tick(0, 0, 0);
    chk("vs_prio_wins", n_win - bw, 24);
    chk("vs_prio_done", n_done - bd, 1);

    // Randomized frames, some cut short by the next vsync.
    for (int f = 0; f < 25; f++) begin
      int nl;
      vsync_pulse();
      nl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H - 1) : H;
      for (int l = 0; l < nl; l++) begin
        int r;
        int np;
        r  = $urandom_range(0, 9);
        np = (r == 0) ? W - 1 : (r == 1) ? W + 1 : W;
        line_body(np, 2);
        line_end($urandom_range(0, 2));
      end
    end
    repeat (4) tick(0, 0, 0);
`ifdef WIN_CTRL_STATUS_EN
    chk("rand_frame_cnt", int'(frame_cnt), exp_fcnt & 16'hFFFF);
    chk("rand_abort_cnt", int'(abort_cnt), exp_acnt);
`endif

    // Asynchronous reset in the middle of a line.
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      line_body(W, 0);
      line_end(1);
    end
    line_body(4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midline_rst");
    for (int k = cyc + 1; k < cyc + 8; k++) begin
      exp_v[k] = 1'b0; exp_done[k] = 1'b0; exp_abort[k] = 1'b0;
    end
    armed = 0; started = 0; line_live = 0; row = 0;
    exp_err = 0; exp_fcnt = 0; exp_acnt = 0;
    tick(0, 1, 1);
    tick(0, 1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bw = n_win;
    repeat (3) tick(0, 1, 1);
    tick(0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      line_body(W, 0);
      line_end(1);
    end
    chk("no_win_before_vsync", n_win - bw, 0);

    // Three good frames then one aborted frame.
    bd = n_done; ba = n_abort;
    for (int f = 0; f < 3; f++) send_frame(H, W, 0);
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      line_body(W, 0);
      line_end(1);
    end
    vsync_pulse();
    repeat (3) tick(0, 0, 0);
    chk("status_done_pulses", n_done - bd, 3);
    chk("status_abort_pulses", n_abort - ba, 1);
`ifdef WIN_CTRL_STATUS_EN
    chk("frame_cnt", int'(frame_cnt), 3);
    chk("abort_cnt", int'(abort_cnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
